// File: rtl/window_fifo_buffer_pkg.sv
// Helpers shared by the datapath buffers: modular pointer arithmetic and
// width derivation for arbitrary (including non-power-of-two) depths.
package window_fifo_buffer_pkg;

  function automatic bit depth_pow2(input int unsigned depth);
    return (depth & (depth - 1)) == 0;
  endfunction

  function automatic int unsigned cnt_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

  // ptr < depth and inc <= depth, so a single conditional subtract suffices
  function automatic int unsigned wrap_add(input int unsigned ptr,
                                           input int unsigned inc,
                                           input int unsigned depth);
    int unsigned sum;
    sum = ptr + inc;
    if (depth_pow2(depth))
      return sum & (depth - 1);
    return (sum >= depth) ? sum - depth : sum;
  endfunction

endpackage

// File: rtl/window_fifo_buffer_wrap_index.sv
// Combinational modular adder: idx = (ptr + inc) mod DEPTH.
module window_fifo_buffer_wrap_index
  import window_fifo_buffer_pkg::*;
#(
  parameter int DEPTH      = 8,
  parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic [ADDR_WIDTH-1:0] ptr_i,
  input  logic [ADDR_WIDTH:0]   inc_i,
  output logic [ADDR_WIDTH-1:0] idx_o
);

  always_comb begin
    idx_o = ADDR_WIDTH'(wrap_add(32'(ptr_i), 32'(inc_i), DEPTH));
  end

endmodule

// File: rtl/window_fifo_buffer.sv
// Circular multi-word FIFO: PAR_WRITE words in per push, a PAR_READ-word
// sliding window out, RD_STRIDE words retired per pop.
module window_fifo_buffer
  import window_fifo_buffer_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 8,
  parameter int PAR_WRITE  = 2,
  parameter int PAR_READ   = 4,
  parameter int RD_STRIDE  = 1,
  parameter int ADDR_WIDTH = $clog2(DEPTH),
  parameter int CNT_WIDTH  = cnt_width(DEPTH)
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           clear,
  input  logic                           wr_valid,
  output logic                           wr_ready,
  input  logic [PAR_WRITE*DATA_WIDTH-1:0] din,
  output logic                           wr_drop,
  output logic                           rd_valid,
  input  logic                           rd_ready,
  output logic [PAR_READ*DATA_WIDTH-1:0] dout,
  output logic [CNT_WIDTH-1:0]           count,
  output logic                           full,
  output logic                           empty
);

  logic [ADDR_WIDTH-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CNT_WIDTH-1:0]  count_q, count_d;
  logic                  drop_q, drop_d;
  logic [ADDR_WIDTH-1:0] wptr_nxt, rptr_nxt;
  logic [ADDR_WIDTH-1:0] wr_idx [PAR_WRITE];
  logic [ADDR_WIDTH-1:0] rd_idx [PAR_READ];
  logic [DATA_WIDTH-1:0] mem_q  [DEPTH];
  logic                  push, pop;

  assign wr_ready = (count_q <= CNT_WIDTH'(DEPTH - PAR_WRITE));
  assign rd_valid = (count_q >= CNT_WIDTH'(PAR_READ));
  assign full     = (count_q == CNT_WIDTH'(DEPTH));
  assign empty    = (count_q == '0);
  assign count    = count_q;
  assign wr_drop  = drop_q;

  // clear suppresses the write as well as the pointer updates
  assign push = wr_valid & wr_ready & ~clear;
  assign pop  = rd_valid & rd_ready;

  window_fifo_buffer_wrap_index #(.DEPTH(DEPTH), .ADDR_WIDTH(ADDR_WIDTH)) u_wptr_inc (
    .ptr_i(wptr_q), .inc_i((ADDR_WIDTH+1)'(PAR_WRITE)), .idx_o(wptr_nxt));

  window_fifo_buffer_wrap_index #(.DEPTH(DEPTH), .ADDR_WIDTH(ADDR_WIDTH)) u_rptr_inc (
    .ptr_i(rptr_q), .inc_i((ADDR_WIDTH+1)'(RD_STRIDE)), .idx_o(rptr_nxt));

  for (genvar k = 0; k < PAR_WRITE; k++) begin : g_wr_lane
    window_fifo_buffer_wrap_index #(.DEPTH(DEPTH), .ADDR_WIDTH(ADDR_WIDTH)) u_idx (
      .ptr_i(wptr_q), .inc_i((ADDR_WIDTH+1)'(k)), .idx_o(wr_idx[k]));
  end

  for (genvar i = 0; i < PAR_READ; i++) begin : g_rd_lane
    window_fifo_buffer_wrap_index #(.DEPTH(DEPTH), .ADDR_WIDTH(ADDR_WIDTH)) u_idx (
      .ptr_i(rptr_q), .inc_i((ADDR_WIDTH+1)'(i)), .idx_o(rd_idx[i]));
    assign dout[i*DATA_WIDTH +: DATA_WIDTH] = rd_valid ? mem_q[rd_idx[i]] : '0;
  end

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    drop_d  = 1'b0;
    if (clear) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      drop_d = wr_valid & ~wr_ready;
      if (push) wptr_d = wptr_nxt;
      if (pop)  rptr_d = rptr_nxt;
      count_d = count_q + (push ? CNT_WIDTH'(PAR_WRITE) : '0)
                        - (pop  ? CNT_WIDTH'(RD_STRIDE) : '0);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      drop_q  <= 1'b0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      drop_q  <= drop_d;
    end
  end

  // Storage carries no reset; occupancy alone decides what is valid
  always_ff @(posedge clk) begin
    if (push) begin
      for (int k = 0; k < PAR_WRITE; k++)
        mem_q[wr_idx[k]] <= din[k*DATA_WIDTH +: DATA_WIDTH];
    end
  end

endmodule

// File: tb/tb_window_fifo_buffer.sv
// Directed bench for window_fifo_buffer with a non-power-of-two depth.
module tb_window_fifo_buffer;

  localparam int DW = 16;
  localparam int DEPTH = 6;
  localparam int PW = 2;
  localparam int PR = 3;
  localparam int RS = 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic              clk = 1'b0;
  logic              rst_n, clear, wr_valid, rd_ready;
  logic [PW*DW-1:0]  din;
  logic              wr_ready, wr_drop, rd_valid, full, empty;
  logic [PR*DW-1:0]  dout;
  logic [CW-1:0]     count;

  int n_checks = 0;
  int n_errors = 0;

  window_fifo_buffer #(
    .DATA_WIDTH(DW), .DEPTH(DEPTH), .PAR_WRITE(PW), .PAR_READ(PR), .RD_STRIDE(RS)
  ) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .din(din), .wr_drop(wr_drop),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .dout(dout),
    .count(count), .full(full), .empty(empty)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_win(input string tag, input int l0, input int l1, input int l2);
    check({tag, ".lane0"}, 64'(dout[0*DW +: DW]), 64'(l0));
    check({tag, ".lane1"}, 64'(dout[1*DW +: DW]), 64'(l1));
    check({tag, ".lane2"}, 64'(dout[2*DW +: DW]), 64'(l2));
  endtask

  task automatic push(input int a, input int b);
    wr_valid = 1'b1;
    din = {DW'(b), DW'(a)};
    tick();
    wr_valid = 1'b0;
  endtask

  task automatic pop();
    rd_ready = 1'b1;
    tick();
    rd_ready = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; clear = 1'b0; wr_valid = 1'b0; rd_ready = 1'b0; din = '0;
    tick(); tick();
    check("rst.count", 64'(count), 0);
    check("rst.empty", 64'(empty), 1);
    check("rst.full", 64'(full), 0);
    check("rst.wr_ready", 64'(wr_ready), 1);
    check("rst.rd_valid", 64'(rd_valid), 0);
    rst_n = 1'b1;
    tick();

    // 1: asynchronous reset while holding four words
    push(1, 2); push(3, 4);
    check("t1.count_pre", 64'(count), 4);
    #2 rst_n = 1'b0;
    #1;
    check("t1.count", 64'(count), 0);
    check("t1.empty", 64'(empty), 1);
    check("t1.wr_ready", 64'(wr_ready), 1);
    check("t1.rd_valid", 64'(rd_valid), 0);
    check("t1.dout", 64'(dout), 0);
    tick();
    rst_n = 1'b1;
    tick();

    // 2: fill to full
    push(1, 2); push(3, 4); push(5, 6);
    check("t2.count", 64'(count), 6);
    check("t2.full", 64'(full), 1);
    check("t2.wr_ready", 64'(wr_ready), 0);
    check("t2.rd_valid", 64'(rd_valid), 1);
    check_win("t2.win", 1, 2, 3);

    // 3: overflow is dropped and flagged for one cycle
    push(9, 9);
    check("t3.drop", 64'(wr_drop), 1);
    check("t3.count", 64'(count), 6);
    check_win("t3.win", 1, 2, 3);
    tick();
    check("t3.drop_clr", 64'(wr_drop), 0);

    // 4: wrap-around
    pop(); pop();
    check("t4.count_a", 64'(count), 4);
    check_win("t4.win_a", 3, 4, 5);
    push(7, 8);
    check("t4.full", 64'(full), 1);
    pop(); pop();
    check("t4.count_b", 64'(count), 4);
    check_win("t4.win_b", 5, 6, 7);

    // 5: simultaneous push and pop at count 3
    pop();
    check("t5.count_pre", 64'(count), 3);
    check_win("t5.win_pre", 6, 7, 8);
    wr_valid = 1'b1; din = {DW'(11), DW'(10)}; rd_ready = 1'b1;
    tick();
    wr_valid = 1'b0; rd_ready = 1'b0;
    check("t5.count", 64'(count), 4);
    check_win("t5.win", 7, 8, 10);

    // 6: clear overrides push and pop
    push(12, 13);
    pop();
    check("t6.count_pre", 64'(count), 5);
    clear = 1'b1; wr_valid = 1'b1; rd_ready = 1'b1; din = {DW'(31), DW'(30)};
    tick();
    clear = 1'b0; wr_valid = 1'b0; rd_ready = 1'b0;
    check("t6.count", 64'(count), 0);
    check("t6.empty", 64'(empty), 1);
    check("t6.rd_valid", 64'(rd_valid), 0);
    check("t6.dout", 64'(dout), 0);
    push(20, 21);
    check("t6.count_b", 64'(count), 2);
    check("t6.rd_valid_b", 64'(rd_valid), 0);
    pop();
    check("t6.underflow", 64'(count), 2);
    push(22, 23);
    check("t6.count_c", 64'(count), 4);
    check_win("t6.win", 20, 21, 22);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/window_fifo_buffer.md
Name: window_fifo_buffer

Overview:
- Circular multi-word FIFO for the accelerator datapath: PAR_WRITE words pushed per beat, a sliding window of PAR_READ words presented per beat.
- The consumer retires RD_STRIDE words per pop.
- Adds what the plain circular buffer lacks: pointer and occupancy tracking, valid/ready handshakes on both sides, full/empty status, overflow reporting, and a synchronous flush.
- Sits between an input-feed producer and a PE-array consumer. Supports any DEPTH, including non-power-of-two.

Parameters:
- DATA_WIDTH, 16, bits per word.
- DEPTH, 8, words of storage; any value >= 2. Requires DEPTH >= PAR_WRITE and DEPTH >= PAR_READ.
- PAR_WRITE, 2, words accepted per push.
- PAR_READ, 4, words visible per read window.
- RD_STRIDE, 1, words removed per pop; 1 <= RD_STRIDE <= PAR_READ.
- ADDR_WIDTH, $clog2(DEPTH), pointer width.
- CNT_WIDTH, $clog2(DEPTH+1), occupancy width.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- clear  in  1  synchronous flush.
- wr_valid  in  1  producer offers din.
- wr_ready  out  1  space for PAR_WRITE words.
- din  in  PAR_WRITE*DATA_WIDTH  lane k = word k, lane 0 oldest.
- wr_drop  out  1  one-cycle pulse: wr_valid seen while wr_ready=0.
- rd_valid  out  1  at least PAR_READ words stored.
- rd_ready  in  1  consumer pops RD_STRIDE words.
- dout  out  PAR_READ*DATA_WIDTH  lane i = i-th oldest word.
- count  out  CNT_WIDTH  current occupancy.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - wptr=0, rptr=0, count=0, wr_drop=0.
  - Resulting outputs: wr_ready=1, rd_valid=0, empty=1, full=0, dout=0.
  - Storage array is not reset. Reset asserted mid-operation discards all contents immediately.
- Status is derived combinationally from registered state only:
  - wr_ready = (count <= DEPTH-PAR_WRITE).
  - rd_valid = (count >= PAR_READ).
  - full and empty as defined under Ports.
  - dout forced to 0 whenever rd_valid=0.
- Push (wr_valid & wr_ready at the rising edge):
  - mem[wrap(wptr+k)] <= din lane k, for k = 0..PAR_WRITE-1.
  - wptr <= wrap(wptr+PAR_WRITE).
- Pop (rd_valid & rd_ready at the rising edge):
  - rptr <= wrap(rptr+RD_STRIDE).
  - Only the pointer moves; data is not cleared.
- Read window: dout lane i = mem[wrap(rptr+i)], combinational from rptr and the array.
  - Zero read latency relative to the pointer.
  - A written word becomes visible the cycle after its push edge.
- Occupancy update: count <= count + (push ? PAR_WRITE : 0) - (pop ? RD_STRIDE : 0).
  - A simultaneous push and pop are both accepted, judged on pre-edge status.
  - No bypass: a pushed word cannot satisfy rd_valid in the same cycle.
- Wrap arithmetic:
  - Operands are below DEPTH and increments are at most DEPTH, so sums are < 2*DEPTH and are computed ADDR_WIDTH+1 bits wide.
  - wrap(x) = x >= DEPTH ? x-DEPTH : x.
  - For power-of-two DEPTH, truncate to ADDR_WIDTH bits instead.
- Overflow and underflow:
  - A push with wr_ready=0 is ignored; nothing written, no pointer change. wr_drop=1 on the following cycle for one cycle.
  - A pop with rd_valid=0 is ignored silently.
- clear=1 at an edge:
  - wptr=rptr=count=0, wr_drop=0.
  - Overrides any push or pop in the same cycle; no write occurs.
- Word order is preserved across wrap-around; din lane 0 is always older than lane 1.

Decomposition:
- Shared package/header, used by all buffers in the design:
  - the wrap-add function (pointer, increment, DEPTH).
  - the DEPTH_POW2 constant expression.
  - the CNT_WIDTH helper.
- One natural sub-module: wrap_index, a combinational wrap adder. Instantiated once per write lane, once per read lane, and for both pointer updates.
- Control state (pointers, count, wr_drop) lives in the top level.

Test Plan:
Bench configuration: DATA_WIDTH=16, DEPTH=6 (non-power-of-two), PAR_WRITE=2, PAR_READ=3, RD_STRIDE=1.
1. Reset mid-stream: rst_n low while count=4 -> asynchronously count=0, empty=1, wr_ready=1, rd_valid=0, dout=0.
2. Fill to full: push {1,2},{3,4},{5,6} -> count=6, full=1, wr_ready=0, rd_valid=1, dout lanes = 1,2,3.
3. Overflow: wr_valid=1 with din {9,9} while full -> no write, count stays 6, wr_drop=1 for exactly one cycle, dout unchanged 1,2,3.
4. Wrap-around: pop twice (count=4, rptr=2), then push {7,8} into addresses 0,1, then pop twice more -> rptr=4, dout lanes = 5,6,7, count=4.
5. Simultaneous push and pop at count=3: wr_valid=1 with {10,11} and rd_ready=1 -> count=4, dout lane 0 advances by one word, new words are at window end the following cycle.
6. Clear priority: at count=5, clear=1 with wr_valid=1 and rd_ready=1 in the same cycle -> count=0, empty=1, rd_valid=0. Next push {20,21} occupies addresses 0,1.
